// File: rtl/dsp_out_requant_if.sv
// dsp_out_requant_if: streaming handshake bundle between FIR source, requantizer and consumer
// Ports (signals):
//   src_data_in/src_valid_in/src_ready_out  - wide sample input handshake
//   dst_data_out/dst_valid_out/dst_ready_in - requantized sample output handshake
// Modports: master = the environment driving the block, slave = the requantizer itself.
interface dsp_out_requant_if #(
    parameter int IN_WIDTH  = 37,
    parameter int OUT_WIDTH = 16
);
    logic [IN_WIDTH-1:0]  src_data_in;
    logic                 src_valid_in;
    logic                 src_ready_out;
    logic [OUT_WIDTH-1:0] dst_data_out;
    logic                 dst_valid_out;
    logic                 dst_ready_in;
    modport master (output src_data_in, src_valid_in, dst_ready_in,
                    input  src_ready_out, dst_data_out, dst_valid_out);
    modport slave  (input  src_data_in, src_valid_in, dst_ready_in,
                    output src_ready_out, dst_data_out, dst_valid_out);
endinterface

// File: rtl/dsp_out_requant.sv
// dsp_out_requant: round, shift and saturate wide FIR results into a first-word-fall-through output FIFO
// Ports:
//   clk, arst      - clock and asynchronous active-high reset
//   shift[5:0]     - arithmetic right-shift amount, captured with each sample
//   round_en       - round-half-up before the shift, captured with each sample
//   sat_clr        - synchronous clear of the sticky saturation flag
//   bus (slave)    - src/dst valid-ready handshakes
//   sat_flag       - sticky saturation indication
//   fifo_count     - output FIFO occupancy
module dsp_out_requant #(
    parameter int IN_WIDTH  = 37,
    parameter int OUT_WIDTH = 16,
    parameter int DEPTH     = 4
) (
    input  logic                       clk,
    input  logic                       arst,
    input  logic [5:0]                 shift,
    input  logic                       round_en,
    input  logic                       sat_clr,
    dsp_out_requant_if.slave           bus,
    output logic                       sat_flag,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count
);
    localparam int CW = $clog2(DEPTH+1);
    localparam int AW = $clog2(DEPTH);
    localparam logic signed [IN_WIDTH:0] MAXV = {{(IN_WIDTH-OUT_WIDTH+2){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [IN_WIDTH:0] MINV = ~MAXV;

    logic                 stage_valid_q;
    logic [IN_WIDTH-1:0]  stage_data_q;
    logic [5:0]           stage_shift_q;
    logic                 stage_rnd_q;
    logic [OUT_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]        count_q, count_d;
    logic [OUT_WIDTH-1:0] last_q;
    logic                 sat_q, sat_d;
    logic [5:0]           s;
    logic [IN_WIDTH:0]    rnd_add;
    logic signed [IN_WIDTH:0] sum, shr;
    logic                 hi, lo, sat_hit, accept, pop;
    logic [OUT_WIDTH-1:0] res;

    // One guard bit above IN_WIDTH keeps the rounding add from overflowing.
    always_comb begin
        s       = (stage_shift_q > 6'(IN_WIDTH-1)) ? 6'(IN_WIDTH-1) : stage_shift_q;
        rnd_add = (stage_rnd_q && s != '0) ? (IN_WIDTH+1)'(1) << (s - 6'd1) : '0;
        sum     = $signed({stage_data_q[IN_WIDTH-1], stage_data_q}) + $signed(rnd_add);
        shr     = sum >>> s;
        hi      = shr > MAXV;
        lo      = shr < MINV;
        res     = hi ? MAXV[OUT_WIDTH-1:0] : lo ? MINV[OUT_WIDTH-1:0] : shr[OUT_WIDTH-1:0];
        sat_hit = stage_valid_q && (hi || lo);
        accept  = bus.src_valid_in && bus.src_ready_out;
        pop     = (count_q != '0) && bus.dst_ready_in;
        count_d = count_q + CW'(stage_valid_q) - CW'(pop);
        sat_d   = sat_hit ? 1'b1 : sat_clr ? 1'b0 : sat_q;
    end

    // Ready looks only at registered state so the consumer never reaches the source combinationally.
    assign bus.src_ready_out = (count_q + CW'(stage_valid_q)) < CW'(DEPTH);
    assign bus.dst_valid_out = count_q != '0;
    // When empty the last popped word is shown instead of a stale memory slot.
    assign bus.dst_data_out  = (count_q != '0) ? mem_q[rd_ptr_q] : last_q;
    assign fifo_count        = count_q;
    assign sat_flag          = sat_q;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            stage_valid_q <= 1'b0;
            stage_data_q  <= '0;
            stage_shift_q <= '0;
            stage_rnd_q   <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            last_q        <= '0;
            sat_q         <= 1'b0;
        end else begin
            stage_valid_q <= accept;
            if (accept) begin
                stage_data_q  <= bus.src_data_in;
                stage_shift_q <= shift;
                stage_rnd_q   <= round_en;
            end
            if (stage_valid_q) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
                last_q   <= mem_q[rd_ptr_q];
            end
            count_q <= count_d;
            sat_q   <= sat_d;
        end
    end

    always_ff @(posedge clk) begin
        if (stage_valid_q) mem_q[wr_ptr_q] <= res;
    end
endmodule

// File: tb/tb_dsp_out_requant.sv
// tb_dsp_out_requant: directed and randomized self-checking bench for dsp_out_requant
module tb_dsp_out_requant;
    logic       clk = 1'b0;
    logic       arst = 1'b0;
    logic [5:0] shift = '0;
    logic       round_en = 1'b0;
    logic       sat_clr = 1'b0;
    logic       sat_flag;
    logic [2:0] fifo_count;
    int         tests = 0;
    int         fails = 0;

    dsp_out_requant_if bus();

    dsp_out_requant dut (
        .clk(clk), .arst(arst), .shift(shift), .round_en(round_en), .sat_clr(sat_clr),
        .bus(bus), .sat_flag(sat_flag), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    // Reference requantizer: floor division by 2^s after optional half-LSB bias, then clamp.
    function automatic void ref_q(input longint d, input int sh, input bit rnd,
                                  output logic [15:0] res, output bit sat);
        longint s, p, v;
        s = (sh > 36) ? 36 : sh;
        p = longint'(1) << s;
        v = d + ((rnd && s > 0) ? p / 2 : 0);
        v = (v >= 0) ? v / p : -((-v + p - 1) / p);
        sat = (v > 32767) || (v < -32768);
        v = (v > 32767) ? 32767 : ((v < -32768) ? -32768 : v);
        res = v[15:0];
    endfunction

    task automatic send(input logic [36:0] d, input logic [5:0] sh, input logic rnd);
        @(negedge clk);
        bus.src_data_in = d;
        shift = sh;
        round_en = rnd;
        bus.src_valid_in = 1'b1;
        @(posedge clk);
        #1 bus.src_valid_in = 1'b0;
    endtask

    task automatic test_reset;
        bus.src_data_in = 37'd5;
        bus.src_valid_in = 1'b1;
        @(negedge clk);
        tests++;
        if (fifo_count !== 3'd0 || bus.dst_valid_out !== 1'b0 || bus.dst_data_out !== 16'd0 ||
            sat_flag !== 1'b0 || bus.src_ready_out !== 1'b1)
            begin fails++; $display("FAIL reset_state: cnt=%0d dv=%b dd=%0d sat=%b rdy=%b want 0 0 0 0 1",
                fifo_count, bus.dst_valid_out, bus.dst_data_out, sat_flag, bus.src_ready_out); end
        arst = 1'b0;
        @(posedge clk);
        #1 bus.src_valid_in = 1'b0;
        @(posedge clk);
        @(negedge clk);
        tests++;
        if (bus.dst_valid_out !== 1'b1 || bus.dst_data_out !== 16'd5)
            begin fails++; $display("FAIL first_after_reset: dv=%b dd=%0d want dv=1 dd=5",
                bus.dst_valid_out, bus.dst_data_out); end
        repeat (2) @(posedge clk);
    endtask

    task automatic test_rounding;
        int  din[4]  = '{40, 40, -40, -41};
        bit  rnd[4]  = '{1'b1, 1'b0, 1'b1, 1'b1};
        int  want[4] = '{3, 2, -2, -3};
        for (int i = 0; i < 4; i++) begin
            send(37'(din[i]), 6'd4, rnd[i]);
            @(posedge clk);
            @(negedge clk);
            tests++;
            if (bus.dst_valid_out !== 1'b1 || bus.dst_data_out !== 16'(want[i]))
                begin fails++; $display("FAIL rounding[%0d]: dv=%b dd=%0d want dv=1 dd=%0d",
                    i, bus.dst_valid_out, $signed(bus.dst_data_out), want[i]); end
        end
        tests++;
        if (sat_flag !== 1'b0) begin fails++; $display("FAIL rounding_sat: sat=%b want 0", sat_flag); end
        repeat (2) @(posedge clk);
    endtask

    task automatic test_saturation;
        send(37'(1 << 20), 6'd0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        tests++;
        if (bus.dst_data_out !== 16'h7fff || sat_flag !== 1'b1)
            begin fails++; $display("FAIL sat_pos: dd=%0d sat=%b want 32767 1", bus.dst_data_out, sat_flag); end
        send(37'(-(1 << 20)), 6'd0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        tests++;
        if (bus.dst_data_out !== 16'h8000)
            begin fails++; $display("FAIL sat_neg: dd=%h want 8000", bus.dst_data_out); end
        sat_clr = 1'b1;
        @(posedge clk);
        #1 sat_clr = 1'b0;
        @(negedge clk);
        tests++;
        if (sat_flag !== 1'b0) begin fails++; $display("FAIL sat_clear: sat=%b want 0", sat_flag); end
    endtask

    task automatic test_collision;
        @(negedge clk);
        bus.src_data_in = 37'(1 << 20);
        shift = 6'd0;
        bus.src_valid_in = 1'b1;
        @(posedge clk);
        #1 bus.src_valid_in = 1'b0;
        sat_clr = 1'b1;
        @(posedge clk);
        #1 sat_clr = 1'b0;
        @(negedge clk);
        tests++;
        if (sat_flag !== 1'b1 || bus.dst_data_out !== 16'h7fff)
            begin fails++; $display("FAIL clr_collision: sat=%b dd=%0d want 1 32767", sat_flag, bus.dst_data_out); end
        sat_clr = 1'b1;
        @(posedge clk);
        #1 sat_clr = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_backpressure;
        int  idx = 1;
        int  nxt = 1;
        bit  will_acc, will_pop;
        bus.dst_ready_in = 1'b0;
        shift = 6'd0;
        round_en = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            bus.src_valid_in = 1'b1;
            bus.src_data_in = 37'(idx);
            will_acc = bus.src_ready_out;
            @(posedge clk);
            if (will_acc) idx++;
        end
        @(negedge clk);
        tests++;
        if (idx !== 5 || fifo_count !== 3'd4 || bus.src_ready_out !== 1'b0 || bus.dst_data_out !== 16'd1)
            begin fails++; $display("FAIL bp_full: accepted=%0d cnt=%0d rdy=%b dd=%0d want 4 4 0 1",
                idx - 1, fifo_count, bus.src_ready_out, bus.dst_data_out); end
        bus.dst_ready_in = 1'b1;
        for (int c = 0; c < 40 && nxt <= 6; c++) begin
            bus.src_valid_in = (idx <= 6);
            bus.src_data_in = 37'(idx);
            will_acc = bus.src_valid_in && bus.src_ready_out;
            will_pop = bus.dst_valid_out;
            if (will_pop) begin
                tests++;
                if (bus.dst_data_out !== 16'(nxt))
                    begin fails++; $display("FAIL bp_order: dd=%0d want %0d", bus.dst_data_out, nxt); end
                nxt++;
            end
            @(posedge clk);
            if (will_acc) idx++;
            @(negedge clk);
        end
        bus.src_valid_in = 1'b0;
        tests++;
        if (nxt !== 7) begin fails++; $display("FAIL bp_drain: emitted=%0d want 6", nxt - 1); end
        repeat (2) @(posedge clk);
    endtask

    task automatic test_back_to_back;
        bus.dst_ready_in = 1'b1;
        shift = 6'd0;
        round_en = 1'b0;
        for (int c = 0; c < 22; c++) begin
            @(negedge clk);
            bus.src_valid_in = (c < 20);
            bus.src_data_in = 37'(c * 100 + 7);
            if (c < 20) begin
                tests++;
                if (bus.src_ready_out !== 1'b1)
                    begin fails++; $display("FAIL b2b_ready[%0d]: rdy=%b want 1", c, bus.src_ready_out); end
            end
            if (c >= 2) begin
                tests++;
                if (bus.dst_valid_out !== 1'b1 || bus.dst_data_out !== 16'((c - 2) * 100 + 7))
                    begin fails++; $display("FAIL b2b_data[%0d]: dv=%b dd=%0d want 1 %0d",
                        c, bus.dst_valid_out, bus.dst_data_out, (c - 2) * 100 + 7); end
            end
            @(posedge clk);
        end
        #1 bus.src_valid_in = 1'b0;
    endtask

    task automatic test_random;
        logic [15:0] exp_q[$];
        logic [15:0] st_res;
        logic [15:0] last_pop = 16'd1907;
        bit          st_v = 1'b0, st_sat = 1'b0, m_flag = 1'b0;
        bit          v, rnd, pop, acc;
        int          cnt = 0;
        int          sh;
        longint      r, d;
        for (int c = 0; c < 330; c++) begin
            @(negedge clk);
            tests++;
            if (fifo_count !== 3'(cnt) || bus.src_ready_out !== (cnt + int'(st_v) < 4) ||
                bus.dst_valid_out !== (cnt != 0) || sat_flag !== m_flag)
                begin fails++; $display("FAIL rand_state[%0d]: cnt=%0d rdy=%b dv=%b sat=%b want %0d %b %b %b",
                    c, fifo_count, bus.src_ready_out, bus.dst_valid_out, sat_flag,
                    cnt, cnt + int'(st_v) < 4, cnt != 0, m_flag); end
            tests++;
            if (cnt != 0 ? (exp_q.size() == 0 || bus.dst_data_out !== exp_q[0]) : bus.dst_data_out !== last_pop)
                begin fails++; $display("FAIL rand_data[%0d]: dd=%h want %h", c, bus.dst_data_out,
                    cnt != 0 && exp_q.size() > 0 ? exp_q[0] : last_pop); end
            v = (c < 300) && ($urandom % 4 != 0);
            r = {$urandom, $urandom};
            d = r >>> $urandom_range(27, 62);
            sh = ($urandom_range(0, 3) == 0) ? $urandom_range(37, 63) : $urandom_range(0, 24);
            rnd = $urandom % 2;
            bus.src_valid_in = v;
            bus.src_data_in = d[36:0];
            shift = 6'(sh);
            round_en = rnd;
            bus.dst_ready_in = (c >= 300) || ($urandom % 3 != 0);
            sat_clr = (c < 300) && ($urandom % 16 == 0);
            acc = v && (cnt + int'(st_v) < 4);
            pop = (cnt != 0) && bus.dst_ready_in;
            if (pop && exp_q.size() > 0) last_pop = exp_q.pop_front();
            m_flag = (st_v && st_sat) ? 1'b1 : (sat_clr ? 1'b0 : m_flag);
            cnt = cnt + int'(st_v) - int'(pop);
            if (st_v) exp_q.push_back(st_res);
            st_v = acc;
            if (acc) ref_q(d, sh, rnd, st_res, st_sat);
        end
        @(negedge clk);
        bus.src_valid_in = 1'b0;
        sat_clr = 1'b0;
        bus.dst_ready_in = 1'b1;
        tests++;
        if (fifo_count !== 3'd0 || bus.dst_valid_out !== 1'b0)
            begin fails++; $display("FAIL rand_drain: cnt=%0d dv=%b want 0 0", fifo_count, bus.dst_valid_out); end
        sat_clr = 1'b1;
        @(posedge clk);
        #1 sat_clr = 1'b0;
    endtask

    task automatic test_reset_midop;
        bus.dst_ready_in = 1'b0;
        shift = 6'd0;
        round_en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bus.src_valid_in = 1'b1;
            bus.src_data_in = (k == 0) ? 37'(1 << 20) : 37'(k);
            @(posedge clk);
        end
        #1 bus.src_valid_in = 1'b0;
        @(negedge clk);
        tests++;
        if (fifo_count !== 3'd3 || sat_flag !== 1'b1)
            begin fails++; $display("FAIL midop_pre: cnt=%0d sat=%b want 3 1", fifo_count, sat_flag); end
        #2 arst = 1'b1;
        #1;
        tests++;
        if (fifo_count !== 3'd0 || bus.dst_valid_out !== 1'b0 || sat_flag !== 1'b0 ||
            bus.dst_data_out !== 16'd0 || bus.src_ready_out !== 1'b1)
            begin fails++; $display("FAIL midop_reset: cnt=%0d dv=%b sat=%b dd=%0d rdy=%b want 0 0 0 0 1",
                fifo_count, bus.dst_valid_out, sat_flag, bus.dst_data_out, bus.src_ready_out); end
        @(negedge clk);
        arst = 1'b0;
        bus.dst_ready_in = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            tests++;
            if (bus.dst_valid_out !== 1'b0 || fifo_count !== 3'd0)
                begin fails++; $display("FAIL midop_after[%0d]: dv=%b cnt=%0d want 0 0",
                    c, bus.dst_valid_out, fifo_count); end
        end
    endtask

    initial begin
        bus.src_valid_in = 1'b0;
        bus.src_data_in = '0;
        bus.dst_ready_in = 1'b1;
        #1 arst = 1'b1;
        test_reset;
        test_rounding;
        test_saturation;
        test_collision;
        test_backpressure;
        test_back_to_back;
        test_random;
        test_reset_midop;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/dsp_out_requant.md
DSP_OUT_REQUANT -- requirements
Module: dsp_out_requant

Interface
REQ-001: Parameter IN_WIDTH, default 37, SHALL set the width of the wide FIR result accepted at the input (2*16+5).
REQ-002: Parameter OUT_WIDTH, default 16, SHALL set the width of the signed output sample.
REQ-003: Parameter DEPTH, default 4, SHALL set the output FIFO depth; legal values are powers of two, 2 or greater.
REQ-004: Port clk, input, 1, SHALL be the single clock; all state is rising-edge triggered.
REQ-005: Port arst, input, 1, SHALL be the asynchronous, active-high reset.
REQ-006: Port shift, input, 6, SHALL give the arithmetic right-shift amount applied to each sample.
REQ-007: Port round_en, input, 1, SHALL enable round-half-up before the shift when 1.
REQ-008: Port src_data_in, input, IN_WIDTH, SHALL carry the signed sample from the FIR stage.
REQ-009: Port src_valid_in, input, 1, SHALL mark src_data_in as valid.
REQ-010: Port src_ready_out, output, 1, SHALL indicate that the block accepts a sample this cycle.
REQ-011: Port dst_data_out, output, OUT_WIDTH, SHALL carry the signed requantized sample at the FIFO head.
REQ-012: Port dst_valid_out, output, 1, SHALL indicate that the FIFO is not empty.
REQ-013: Port dst_ready_in, input, 1, SHALL indicate that the consumer accepts dst_data_out.
REQ-014: Port sat_flag, output, 1, SHALL be a sticky indication that saturation occurred.
REQ-015: Port sat_clr, input, 1, SHALL clear sat_flag synchronously.
REQ-016: Port fifo_count, output, $clog2(DEPTH+1), SHALL report the FIFO occupancy.

Function
REQ-017: The block SHALL accept a sample when src_valid_in and src_ready_out are both 1.
REQ-018: On acceptance, the block SHALL capture the sample, shift and round_en together into a single pipeline stage (stage_valid=1).
- Changes to shift or round_en SHALL affect only samples accepted after the change.
REQ-019: The stage SHALL compute the following:
- The effective shift s = min(shift, IN_WIDTH-1).
- If round_en=1 and s>0, add 2^(s-1) in IN_WIDTH+1 bits.
- Arithmetic right-shift by s.
- Saturate to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
REQ-020: A valid stage SHALL write its result into the FIFO on the next edge unconditionally, and the stage SHALL then be empty unless a new sample is accepted on the same edge.
REQ-021: src_ready_out SHALL equal (fifo_count + stage_valid) < DEPTH, derived from registered state only.
- There SHALL be no combinational path from dst_ready_in to src_ready_out.
REQ-022: Latency SHALL be 2 cycles: a sample accepted at edge N is presented with dst_valid_out=1 after edge N+1.
REQ-023: The FIFO SHALL be first-word-fall-through, and a pop SHALL occur when dst_valid_out and dst_ready_in are both 1.
REQ-024: A simultaneous push and pop SHALL leave fifo_count unchanged and preserve order.
- Read and write pointers SHALL wrap modulo DEPTH.
REQ-025: When the FIFO is empty, dst_data_out SHALL hold its last value and dst_valid_out SHALL be 0.
- A pop while empty SHALL be ignored.
REQ-026: sat_flag SHALL be set on any edge where a saturating result is written into the FIFO.
- When saturation and sat_clr occur together, set SHALL win.
- Otherwise sat_clr=1 SHALL clear sat_flag.
REQ-027: Back-to-back acceptance SHALL sustain 1 sample per cycle while the consumer holds dst_ready_in=1.

Reset
REQ-028: Asserting arst SHALL immediately force the following, regardless of the clock:
- stage_valid=0 and pointers=0
- fifo_count=0, dst_valid_out=0, dst_data_out=0
- sat_flag=0
- src_ready_out=1 (since 0<DEPTH)
REQ-029: Reset asserted mid-operation SHALL discard all buffered and in-flight samples, and no partial output SHALL appear after release.
REQ-030: The first sample SHALL be accepted on the first rising edge after arst deasserts.

Verification
REQ-031: Rounding: shift=4, round_en=1, input 40 -> output 3 two cycles later, sat_flag=0; the same with round_en=0 -> output 2.
REQ-032: Negative rounding: shift=4, round_en=1, input -40 -> output -2; input -41 -> output -3.
REQ-033: Saturation: shift=0, input 2^20 -> output 32767, sat_flag=1; input -2^20 -> output -32768; then pulse sat_clr -> sat_flag=0.
REQ-034: Backpressure: dst_ready_in=0, 6 consecutive valid samples 1..6 -> samples 1..4 accepted, fifo_count=4, src_ready_out=0; then raise dst_ready_in -> 1..4 emitted in order, then 5 and 6 are accepted and emitted.
REQ-035: Clear/saturate collision: sat_clr=1 on the same edge a saturating sample is written -> sat_flag remains 1.
REQ-036: Reset mid-operation: with 3 entries buffered and one in the stage, assert arst between edges -> fifo_count=0, dst_valid_out=0 and sat_flag=0 immediately, and no output after release.
